// File: rtl/matrix_pkg.sv
// Shared types and helpers for the dot-matrix owner arbiter.
// Holds the arbiter FSM encoding, the row/column "off" levels of the
// 8x8 matrix and the highest-set-bit priority encoder used for grants.
package matrix_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int          ROWS    = 8;
  localparam logic [7:0]  ROW_OFF = 8'hFF;  // rows are active-low
  localparam logic [7:0]  COL_OFF = 8'h00;  // columns are active-high

  // Width of the priority encoder; requester counts up to this are supported.
  localparam int          PRIO_W  = 32;

  // One-hot of the highest set bit of vec (all zero when vec is zero).
  function automatic logic [PRIO_W-1:0] prio_onehot(input logic [PRIO_W-1:0] vec);
    logic [PRIO_W-1:0] res;
    res = {PRIO_W{1'b0}};
    for (int i = 0; i < PRIO_W; i++) begin
      if (vec[i]) begin
        res    = {PRIO_W{1'b0}};
        res[i] = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Row-scan timebase for the dot-matrix: divides clk down to one row
// period, pulses row_tick on the last cycle of each row and advances
// row_idx in the cycle after that pulse (0..7, wrapping).
module scan_timer
  import matrix_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       row_tick,
  output logic [2:0] row_idx
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  // row_tick is registered, so it is raised one count early.
  localparam logic [15:0] DIV_PRE  = 16'(SCAN_DIV - 2);

  logic [15:0] div_cnt_r;
  logic        row_tick_r;
  logic [2:0]  row_idx_r;

  // Divider, end-of-row pulse and row index advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r  <= 16'd0;
      row_tick_r <= 1'b0;
      row_idx_r  <= 3'd0;
    end else begin
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r <= 16'd0;
      end else begin
        div_cnt_r <= div_cnt_r + 16'd1;
      end
      row_tick_r <= (div_cnt_r == DIV_PRE);
      if (row_tick_r) begin
        if (row_idx_r == 3'(ROWS - 1)) begin
          row_idx_r <= 3'd0;
        end else begin
          row_idx_r <= row_idx_r + 3'd1;
        end
      end
    end
  end

  assign row_tick = row_tick_r;
  assign row_idx  = row_idx_r;

endmodule

// File: rtl/matrix_owner_arb.sv
// Ownership arbiter and row-scan output stage for the shared 8x8
// dot-matrix and buzzer. One source owns the display at a time; ownership
// only changes at frame boundaries (row_tick on row 7), except that an
// owner dropping its request releases the display immediately.
// Optional build macro: DEADTIME_EN -- blanks the row select for the first
// four cycles after every row update to suppress ghosting (needs SCAN_DIV>4).
module matrix_owner_arb
  import matrix_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int MIN_FRAMES = 2,
  parameter int TONE_DIV   = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SRC-1:0]   req,
  input  logic [8*N_SRC-1:0] src_red,
  input  logic [N_SRC-1:0]   src_beep,
  output logic [2:0]         row_idx,
  output logic               row_tick,
  output logic [N_SRC-1:0]   grant,
  output logic [7:0]         hang,
  output logic [7:0]         red,
  output logic               beep
);

  localparam logic [15:0] MIN_W     = 16'(MIN_FRAMES);
  localparam logic [15:0] TONE_LAST = 16'(TONE_DIV - 1);

  logic              row_tick_s;
  logic [2:0]        row_idx_s;
  logic              frame_bnd_s;
  logic              owner_req_s;
  logic              blank_s;
  logic              load_s;
  logic              beep_act_s;
  logic [PRIO_W-1:0] prio_s;
  logic [7:0]        owner_red_s;
  logic [7:0]        row_sel_s;
  logic [15:0]       frame_inc_s;

  arb_state_e        state_r, state_nxt_s;
  logic [N_SRC-1:0]  grant_r, grant_nxt_s;
  logic [15:0]       frame_cnt_r, frame_nxt_s;
  logic [7:0]        row_hang_r;
  logic [7:0]        red_r;
  logic [15:0]       tone_cnt_r;
  logic              beep_r;

  scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_tick (row_tick_s),
    .row_idx  (row_idx_s)
  );

  assign frame_bnd_s = row_tick_s && (row_idx_s == 3'(ROWS - 1));
  assign owner_req_s = |(req & grant_r);
  assign prio_s      = prio_onehot(PRIO_W'(req));
  assign row_sel_s   = ~(8'h80 >> row_idx_s);
  assign beep_act_s  = |(grant_r & src_beep);
  assign blank_s     = (grant_nxt_s == {N_SRC{1'b0}});
  assign load_s      = row_tick_s && (grant_r != {N_SRC{1'b0}});

  // Column data of the current owner for the row being prepared.
  always_comb begin
    owner_red_s = COL_OFF;
    for (int i = 0; i < N_SRC; i++) begin
      owner_red_s = owner_red_s | (src_red[8*i +: 8] & {8{grant_r[i]}});
    end
  end

  // Frame count after the current boundary, saturating at MIN_FRAMES.
  always_comb begin
    if (frame_cnt_r >= MIN_W) begin
      frame_inc_s = frame_cnt_r;
    end else begin
      frame_inc_s = frame_cnt_r + 16'd1;
    end
  end

  // Ownership FSM: grant at frame boundaries, release on request drop.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    frame_nxt_s = frame_cnt_r;
    case (state_r)
      IDLE: begin
        if (frame_bnd_s && (req != {N_SRC{1'b0}})) begin
          state_nxt_s = OWN;
          grant_nxt_s = prio_s[N_SRC-1:0];
          frame_nxt_s = 16'd0;
        end else begin
          state_nxt_s = IDLE;
          grant_nxt_s = {N_SRC{1'b0}};
          frame_nxt_s = 16'd0;
        end
      end
      OWN: begin
        if (!owner_req_s) begin
          // A drop wins over a coincident boundary; re-grant waits a frame.
          state_nxt_s = IDLE;
          grant_nxt_s = {N_SRC{1'b0}};
          frame_nxt_s = 16'd0;
        end else if (frame_bnd_s) begin
          if ((prio_s > PRIO_W'(grant_r)) && (frame_inc_s >= MIN_W)) begin
            grant_nxt_s = prio_s[N_SRC-1:0];
            frame_nxt_s = 16'd0;
          end else begin
            frame_nxt_s = frame_inc_s;
          end
        end else begin
          state_nxt_s = OWN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        grant_nxt_s = {N_SRC{1'b0}};
        frame_nxt_s = 16'd0;
      end
    endcase
  end

  // FSM state, grant and frame counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      grant_r     <= {N_SRC{1'b0}};
      frame_cnt_r <= 16'd0;
    end else begin
      state_r     <= state_nxt_s;
      grant_r     <= grant_nxt_s;
      frame_cnt_r <= frame_nxt_s;
    end
  end

  // Row/column output registers: latch the owner's row on row_tick, blank when unowned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_hang_r <= ROW_OFF;
      red_r      <= COL_OFF;
    end else if (blank_s) begin
      row_hang_r <= ROW_OFF;
      red_r      <= COL_OFF;
    end else if (load_s) begin
      row_hang_r <= row_sel_s;
      red_r      <= owner_red_s;
    end
  end

`ifdef DEADTIME_EN
  logic [2:0] dead_cnt_r;
  logic [7:0] hang_dt_r;

  // Keep rows dark for four cycles after each update, then show the new row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dead_cnt_r <= 3'd0;
      hang_dt_r  <= ROW_OFF;
    end else if (blank_s) begin
      dead_cnt_r <= 3'd0;
      hang_dt_r  <= ROW_OFF;
    end else if (load_s) begin
      dead_cnt_r <= 3'd4;
      hang_dt_r  <= ROW_OFF;
    end else if (dead_cnt_r > 3'd1) begin
      dead_cnt_r <= dead_cnt_r - 3'd1;
    end else if (dead_cnt_r == 3'd1) begin
      dead_cnt_r <= 3'd0;
      hang_dt_r  <= row_hang_r;
    end
  end

  assign hang = hang_dt_r;
`else
  assign hang = row_hang_r;
`endif

  // Buzzer square wave for the owner; held low whenever it is not enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt_r <= 16'd0;
      beep_r     <= 1'b0;
    end else if (beep_act_s) begin
      if (tone_cnt_r == TONE_LAST) begin
        tone_cnt_r <= 16'd0;
        beep_r     <= ~beep_r;
      end else begin
        tone_cnt_r <= tone_cnt_r + 16'd1;
      end
    end else begin
      tone_cnt_r <= 16'd0;
      beep_r     <= 1'b0;
    end
  end

  assign row_tick = row_tick_s;
  assign row_idx  = row_idx_s;
  assign grant    = grant_r;
  assign red      = red_r;
  assign beep     = beep_r;

endmodule
